// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, byte-addressable RV32 data memory, MEM/WB register.
// Provides the MEM and WB forwarding/writeback signals consumed by EX and the register file.
module mem_stage #(
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned DMEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_ex,
  input  logic [31:0] rs2_data_ex_out,
  input  logic [4:0]  rd_ex_out,
  input  logic        regwrite_ex_out,
  input  logic        memread_ex,
  input  logic        memwrite_ex,
  input  logic        memtoreg_ex,
  input  logic [2:0]  loadtype_ex,
  input  logic [2:0]  strtype_ex,
  output logic [31:0] alu_result_mem,
  output logic [4:0]  rd_mem_out,
  output logic        regwrite_mem_out,
  output logic [31:0] alu_result_wb,
  output logic [4:0]  rd_wb_out,
  output logic        regwrite_wb_out,
  output logic [31:0] wb_data,
  output logic        mem_fault_wb
);

  logic [31:0] rs2_mem;
  logic        memread_mem, memwrite_mem, memtoreg_mem;
  logic [2:0]  loadtype_mem, strtype_mem;

  logic        memtoreg_wb;
  logic [31:0] load_data_wb;

  logic [31:0] dmem [DMEM_WORDS];

  logic [DMEM_AW-1:0] widx;
  logic [1:0]         lane;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_data;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic               ld_fault, st_fault, fault, store_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_mem   <= '0;
      rs2_mem          <= '0;
      rd_mem_out       <= '0;
      regwrite_mem_out <= 1'b0;
      memread_mem      <= 1'b0;
      memwrite_mem     <= 1'b0;
      memtoreg_mem     <= 1'b0;
      loadtype_mem     <= '0;
      strtype_mem      <= '0;
    end else begin
      alu_result_mem   <= alu_result_ex;
      rs2_mem          <= rs2_data_ex_out;
      rd_mem_out       <= rd_ex_out;
      regwrite_mem_out <= regwrite_ex_out;
      memread_mem      <= memread_ex;
      memwrite_mem     <= memwrite_ex;
      memtoreg_mem     <= memtoreg_ex;
      loadtype_mem     <= loadtype_ex;
      strtype_mem      <= strtype_ex;
    end
  end

  // Upper address bits are ignored, so accesses wrap around the array.
  assign widx    = alu_result_mem[DMEM_AW+1:2];
  assign lane    = alu_result_mem[1:0];
  assign rd_word = dmem[widx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    ld_fault  = 1'b0;
    case (loadtype_mem)
      3'b000: load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100: load_data = {24'h0, rd_byte};
      3'b001: begin
        load_data = {{16{rd_half[15]}}, rd_half};
        ld_fault  = lane[0];
      end
      3'b101: begin
        load_data = {16'h0, rd_half};
        ld_fault  = lane[0];
      end
      3'b010: begin
        load_data = rd_word;
        ld_fault  = (lane != 2'b00);
      end
      default: ld_fault = 1'b1;
    endcase
  end

  always_comb begin
    be       = '0;
    wdata    = '0;
    st_fault = 1'b0;
    case (strtype_mem)
      3'b000: begin
        be    = 4'b0001 << lane;
        wdata = {4{rs2_mem[7:0]}};
      end
      3'b001: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rs2_mem[15:0]}};
        st_fault = lane[0];
      end
      3'b010: begin
        be       = 4'b1111;
        wdata    = rs2_mem;
        st_fault = (lane != 2'b00);
      end
      default: st_fault = 1'b1;
    endcase
  end

  assign fault    = (memread_mem && memwrite_mem) ||
                    (memread_mem && ld_fault) ||
                    (memwrite_mem && st_fault);
  assign store_en = memwrite_mem && !fault;

  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) dmem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_wb   <= '0;
      rd_wb_out       <= '0;
      regwrite_wb_out <= 1'b0;
      memtoreg_wb     <= 1'b0;
      load_data_wb    <= '0;
      mem_fault_wb    <= 1'b0;
    end else begin
      alu_result_wb   <= alu_result_mem;
      rd_wb_out       <= rd_mem_out;
      regwrite_wb_out <= regwrite_mem_out && !(fault && memread_mem);
      memtoreg_wb     <= memtoreg_mem;
      load_data_wb    <= fault ? '0 : load_data;
      mem_fault_wb    <= fault;
    end
  end

  assign wb_data = memtoreg_wb ? load_data_wb : alu_result_wb;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a byte-array memory model executed in program order.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_ex, rs2_data_ex_out;
  logic [4:0]  rd_ex_out;
  logic        regwrite_ex_out, memread_ex, memwrite_ex, memtoreg_ex;
  logic [2:0]  loadtype_ex, strtype_ex;
  logic [31:0] alu_result_mem, alu_result_wb, wb_data;
  logic [4:0]  rd_mem_out, rd_wb_out;
  logic        regwrite_mem_out, regwrite_wb_out, mem_fault_wb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_WORDS(1024), .DMEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .alu_result_ex(alu_result_ex), .rs2_data_ex_out(rs2_data_ex_out),
    .rd_ex_out(rd_ex_out), .regwrite_ex_out(regwrite_ex_out),
    .memread_ex(memread_ex), .memwrite_ex(memwrite_ex), .memtoreg_ex(memtoreg_ex),
    .loadtype_ex(loadtype_ex), .strtype_ex(strtype_ex),
    .alu_result_mem(alu_result_mem), .rd_mem_out(rd_mem_out),
    .regwrite_mem_out(regwrite_mem_out), .alu_result_wb(alu_result_wb),
    .rd_wb_out(rd_wb_out), .regwrite_wb_out(regwrite_wb_out),
    .wb_data(wb_data), .mem_fault_wb(mem_fault_wb)
  );

  typedef struct {
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr;
    logic [2:0]  lt, st;
  } ins_t;

  typedef struct {
    logic [31:0] alu_mem, wb_data, alu_wb;
    logic [4:0]  rd_mem, rd_wb;
    logic        rw_mem, rw_wb, fault;
  } obs_t;

  typedef struct {
    logic [31:0] wb_data;
    logic        rw_wb, fault;
  } exp_t;

  ins_t prog[$];
  obs_t obs [256];
  exp_t expq [256];
  logic [7:0] mmem [4096];

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic mtr,
                              input logic [2:0] lt, input logic [2:0] st);
    ins_t r;
    r.alu = alu; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.mr = mr; r.mw = mw; r.mtr = mtr;
    r.lt = lt; r.st = st;
    return r;
  endfunction

  function automatic ins_t st_op(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] st);
    return mk(addr, data, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, st);
  endfunction

  function automatic ins_t ld_op(input logic [31:0] addr, input logic [2:0] lt, input logic [4:0] rd);
    return mk(addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, 1'b1, lt, 3'b000);
  endfunction

  // Architectural model: sizes from funct3, alignment by modulo, little-endian byte array.
  task automatic model_exec(input ins_t in, output exp_t e);
    int unsigned a = 32'(in.alu[11:0]);
    int unsigned lsz = 1, ssz = 1;
    bit lres = 0, sres = 0, flt;
    logic [31:0] ld = '0;
    case (in.lt)
      3'd0, 3'd4: lsz = 1;
      3'd1, 3'd5: lsz = 2;
      3'd2:       lsz = 4;
      default:    lres = 1;
    endcase
    case (in.st)
      3'd0: ssz = 1;
      3'd1: ssz = 2;
      3'd2: ssz = 4;
      default: sres = 1;
    endcase
    flt = (in.mr && in.mw) || (in.mr && (lres || (a % lsz) != 0)) ||
          (in.mw && (sres || (a % ssz) != 0));
    if (in.mr && !flt) begin
      for (int unsigned k = 0; k < lsz; k++) ld = ld | (32'(mmem[a+k]) << (8*k));
      if (!in.lt[2] && lsz == 1 && ld[7])  ld = ld | 32'hFFFF_FF00;
      if (!in.lt[2] && lsz == 2 && ld[15]) ld = ld | 32'hFFFF_0000;
    end
    if (in.mw && !flt)
      for (int unsigned k = 0; k < ssz; k++) mmem[a+k] = in.rs2[8*k +: 8];
    e.wb_data = in.mtr ? ld : in.alu;
    e.rw_wb   = in.rw && !(flt && in.mr);
    e.fault   = flt;
  endtask

  task automatic drive(input ins_t in);
    alu_result_ex = in.alu; rs2_data_ex_out = in.rs2; rd_ex_out = in.rd;
    regwrite_ex_out = in.rw; memread_ex = in.mr; memwrite_ex = in.mw;
    memtoreg_ex = in.mtr; loadtype_ex = in.lt; strtype_ex = in.st;
  endtask

  // Issues prog one per cycle, records MEM-stage and WB-stage views of each instruction.
  task automatic run_prog();
    int n = prog.size();
    ins_t bub = mk('0, '0, '0, 0, 0, 0, 0, '0, '0);
    exp_t e;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        drive(prog[i]);
        model_exec(prog[i], e);
        expq[i] = e;
      end else begin
        drive(bub);
      end
      @(posedge clk); #1;
      if (i < n) begin
        obs[i].alu_mem = alu_result_mem; obs[i].rd_mem = rd_mem_out; obs[i].rw_mem = regwrite_mem_out;
      end
      if (i > 0) begin
        obs[i-1].wb_data = wb_data; obs[i-1].alu_wb = alu_result_wb; obs[i-1].rd_wb = rd_wb_out;
        obs[i-1].rw_wb = regwrite_wb_out; obs[i-1].fault = mem_fault_wb;
      end
    end
  endtask

  task automatic test_reset();
    drive(mk('0, '0, '0, 0, 0, 0, 0, '0, '0));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({alu_result_mem, rd_mem_out, regwrite_mem_out, alu_result_wb, rd_wb_out,
         regwrite_wb_out, wb_data, mem_fault_wb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mem=%h wb=%h wbd=%h flt=%b required all zero",
               alu_result_mem, alu_result_wb, wb_data, mem_fault_wb);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_pipe();
    prog.delete();
    prog.push_back(mk(32'h1234, 32'h0, 5'd7, 1, 0, 0, 0, 3'b000, 3'b000));
    run_prog();
    checks++;
    if (obs[0].alu_mem !== 32'h1234 || obs[0].rd_mem !== 5'd7 || obs[0].rw_mem !== 1'b1) begin
      errors++;
      $display("FAIL alu_mem_stage: got %h/%0d/%b required 00001234/7/1",
               obs[0].alu_mem, obs[0].rd_mem, obs[0].rw_mem);
    end
    checks++;
    if (obs[0].wb_data !== 32'h1234 || obs[0].rd_wb !== 5'd7 || obs[0].rw_wb !== 1'b1 ||
        obs[0].alu_wb !== 32'h1234) begin
      errors++;
      $display("FAIL alu_wb_stage: got %h/%0d/%b required 00001234/7/1",
               obs[0].wb_data, obs[0].rd_wb, obs[0].rw_wb);
    end
  endtask

  task automatic test_load_sizes();
    logic [31:0] req [6];
    req = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hDEAD_BEEF, 32'h0000_0020};
    prog.delete();
    prog.push_back(st_op(32'h20, 32'hDEAD_BEEF, 3'b010));
    prog.push_back(ld_op(32'h23, 3'b000, 5'd1));
    prog.push_back(ld_op(32'h23, 3'b100, 5'd2));
    prog.push_back(ld_op(32'h22, 3'b001, 5'd3));
    prog.push_back(ld_op(32'h20, 3'b101, 5'd4));
    prog.push_back(ld_op(32'h20, 3'b010, 5'd5));
    prog.push_back(mk(32'h20, 32'h0, 5'd6, 1, 1, 0, 0, 3'b010, 3'b000));
    run_prog();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i+1].wb_data !== req[i] || obs[i+1].rw_wb !== 1'b1 || obs[i+1].fault !== 1'b0) begin
        errors++;
        $display("FAIL load_size_%0d: got %h rw=%b flt=%b required %h rw=1 flt=0",
                 i, obs[i+1].wb_data, obs[i+1].rw_wb, obs[i+1].fault, req[i]);
      end
    end
  endtask

  task automatic test_store_then_load();
    prog.delete();
    prog.push_back(st_op(32'h21, 32'h0000_0055, 3'b000));
    prog.push_back(ld_op(32'h20, 3'b010, 5'd9));
    run_prog();
    checks++;
    if (obs[1].wb_data !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL sb_then_lw: got %h required deadf55ef-lane DEAD55EF", obs[1].wb_data);
    end
  endtask

  task automatic test_faults();
    prog.delete();
    prog.push_back(ld_op(32'h22, 3'b010, 5'd5));
    prog.push_back(mk(32'h99, 32'h0, 5'd6, 1, 0, 0, 0, 3'b000, 3'b000));
    prog.push_back(st_op(32'h30, 32'h0BAD_CAFE, 3'b010));
    prog.push_back(st_op(32'h31, 32'h0000_1234, 3'b001));
    prog.push_back(ld_op(32'h30, 3'b010, 5'd8));
    run_prog();
    checks++;
    if (obs[0].fault !== 1'b1 || obs[0].rw_wb !== 1'b0 || obs[0].wb_data !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_lw: got flt=%b rw=%b wbd=%h required 1/0/00000000",
               obs[0].fault, obs[0].rw_wb, obs[0].wb_data);
    end
    checks++;
    if (obs[0].rw_mem !== 1'b1) begin
      errors++;
      $display("FAIL fault_rw_mem_unmasked: got %b required 1", obs[0].rw_mem);
    end
    checks++;
    if (obs[1].fault !== 1'b0 || obs[1].wb_data !== 32'h99 || obs[1].rw_wb !== 1'b1) begin
      errors++;
      $display("FAIL fault_one_cycle: got flt=%b wbd=%h rw=%b required 0/00000099/1",
               obs[1].fault, obs[1].wb_data, obs[1].rw_wb);
    end
    checks++;
    if (obs[3].fault !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_sh_flag: got %b required 1", obs[3].fault);
    end
    checks++;
    if (obs[4].wb_data !== 32'h0BAD_CAFE || obs[4].fault !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_sh_suppressed: got %h flt=%b required 0BADCAFE flt=0",
               obs[4].wb_data, obs[4].fault);
    end
  endtask

  task automatic test_wrap();
    prog.delete();
    prog.push_back(st_op(32'h1000, 32'hA5A5_A5A5, 3'b010));
    prog.push_back(ld_op(32'h0, 3'b010, 5'd10));
    run_prog();
    checks++;
    if (obs[1].wb_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL address_wrap: got %h required A5A5A5A5", obs[1].wb_data);
    end
  endtask

  task automatic test_reset_pending_store();
    prog.delete();
    prog.push_back(st_op(32'h10, 32'h1111_2222, 3'b010));
    run_prog();
    drive(mk(32'h77, 32'h0, 5'd3, 1, 0, 0, 0, 3'b000, 3'b000));
    @(posedge clk); #1;
    drive(st_op(32'h10, 32'hCAFE_F00D, 3'b010));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({alu_result_mem, rd_mem_out, regwrite_mem_out, alu_result_wb, rd_wb_out,
         regwrite_wb_out, wb_data, mem_fault_wb} !== '0) begin
      errors++;
      $display("FAIL async_reset_clear: got mem=%h wb=%h wbd=%h required all zero",
               alu_result_mem, alu_result_wb, wb_data);
    end
    drive(mk('0, '0, '0, 0, 0, 0, 0, '0, '0));
    @(posedge clk); #1;
    rst = 1'b0;
    prog.delete();
    prog.push_back(ld_op(32'h10, 3'b010, 5'd4));
    run_prog();
    checks++;
    if (obs[0].alu_mem !== 32'h10 || obs[0].rd_mem !== 5'd4) begin
      errors++;
      $display("FAIL post_reset_mem_stage: got %h/%0d required 00000010/4", obs[0].alu_mem, obs[0].rd_mem);
    end
    checks++;
    if (obs[0].wb_data !== 32'h1111_2222) begin
      errors++;
      $display("FAIL reset_drops_store: got %h required 11112222", obs[0].wb_data);
    end
  endtask

  task automatic test_random();
    int unsigned kind;
    logic [31:0] addr;
    logic [2:0] lts [5];
    lts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    prog.delete();
    for (int unsigned w = 0; w < 16; w++) prog.push_back(st_op(32'h100 + 4*w, $urandom, 3'b010));
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 19);
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if (kind < 4)
        prog.push_back(mk($urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, 0, 3'($urandom), 3'($urandom)));
      else if (kind < 11)
        prog.push_back(mk(addr, 32'h0, 5'($urandom), 1'($urandom), 1, 0, (kind != 10),
                          lts[$urandom_range(0, 4)], 3'($urandom)));
      else if (kind < 17)
        prog.push_back(mk(addr, $urandom, 5'($urandom), 1'($urandom), 0, 1, 0,
                          3'($urandom), 3'($urandom_range(0, 2))));
      else if (kind < 19)
        prog.push_back(mk(addr, $urandom, 5'($urandom), 1'($urandom), (kind == 17), (kind == 18),
                          (kind == 17), 3'($urandom_range(6, 7)), 3'($urandom_range(3, 7))));
      else
        prog.push_back(mk(addr, $urandom, 5'($urandom), 1, 1, 1, 1, 3'd2, 3'd2));
    end
    run_prog();
    for (int i = 0; i < prog.size(); i++) begin
      checks++;
      if (obs[i].wb_data !== expq[i].wb_data || obs[i].rw_wb !== expq[i].rw_wb ||
          obs[i].fault !== expq[i].fault || obs[i].rd_wb !== prog[i].rd ||
          obs[i].alu_mem !== prog[i].alu || obs[i].rw_mem !== prog[i].rw) begin
        errors++;
        $display("FAIL random_%0d: got wbd=%h rw=%b flt=%b rd=%0d required wbd=%h rw=%b flt=%b rd=%0d",
                 i, obs[i].wb_data, obs[i].rw_wb, obs[i].fault, obs[i].rd_wb,
                 expq[i].wb_data, expq[i].rw_wb, expq[i].fault, prog[i].rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = 8'h00;
    test_reset();
    test_alu_pipe();
    test_load_sizes();
    test_store_then_load();
    test_faults();
    test_wrap();
    test_reset_pending_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer side of the EX-stage output bundle: EX/MEM pipeline register, byte-addressable data memory with RV32 load/store sizing, MEM/WB pipeline register.
- Produces the forwarding/writeback signals the EX stage bypasses from: alu_result_mem, rd_mem_out, regwrite_mem_out, alu_result_wb, rd_wb_out, regwrite_wb_out, wb_data.
- Sits between EX and the register-file write port of the 5-stage pipeline.

Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words.
- DMEM_AW, 10, word-index width; must equal log2(DMEM_WORDS).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_result_ex  in  32  ALU result / effective address from EX.
- rs2_data_ex_out  in  32  forwarded store data from EX.
- rd_ex_out  in  5  destination register from EX.
- regwrite_ex_out  in  1  register write enable from EX.
- memread_ex, memwrite_ex, memtoreg_ex  in  1 each  memory controls from EX.
- loadtype_ex  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- strtype_ex  in  3  store funct3: 000 SB, 001 SH, 010 SW.
- alu_result_mem  out  32  EX/MEM registered ALU result.
- rd_mem_out  out  5  EX/MEM registered rd.
- regwrite_mem_out  out  1  EX/MEM registered regwrite.
- alu_result_wb  out  32  MEM/WB registered ALU result.
- rd_wb_out  out  5  MEM/WB registered rd.
- regwrite_wb_out  out  1  MEM/WB registered regwrite; forced 0 on a faulting load.
- wb_data  out  32  combinational: memtoreg_wb ? load_data_wb : alu_result_wb.
- mem_fault_wb  out  1  MEM/WB registered fault flag for the instruction now in WB.

Behaviour:
- Reset: async rst clears all EX/MEM and MEM/WB registers. All outputs are 0, including wb_data. Memory contents are not reset; the simulation initial value is 0.
- Latency: EX values captured at edge N appear on the *_mem outputs. The same instruction appears on the *_wb outputs after edge N+1. One instruction per cycle, no stall or backpressure.
- Address decode: byte address A = alu_result_mem. Word index = A[DMEM_AW+1:2]; upper bits are ignored, so addresses wrap. Byte lane = A[1:0]. Little-endian.
- Store: when memwrite_mem is 1 and there is no fault, the memory is written at the clock edge ending the MEM cycle.
  - SB writes byte lane A[1:0] with rs2[7:0].
  - SH writes lanes {A[1],0} and {A[1],1} with rs2[15:0].
  - SW writes the full word.
  - Unaddressed lanes are preserved.
  - No write occurs while rst is high.
- Load: read is combinational from the word array during the MEM cycle; the result is registered into load_data_wb.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
- Fault is evaluated in MEM and registered to mem_fault_wb. Any of the following is a fault:
  - Halfword access with A[0]=1.
  - Word access with A[1:0]!=0.
  - Reserved loadtype when memread=1, or reserved strtype when memwrite=1.
  - memread and memwrite both 1.
- On fault:
  - The store is suppressed.
  - load_data_wb = 0.
  - regwrite_wb_out is forced 0 when memread_mem=1.
  - mem_fault_wb = 1 for exactly that instruction's WB cycle.
  - regwrite_mem_out is not masked.
- Store followed by load to the same word in the next cycle: the load returns the newly written data, because the write completes at the edge before the load's MEM cycle.
- Load with memtoreg=0: memory is still read, but wb_data = alu_result_wb.
- Reset asserted mid-operation: in-flight EX/MEM and MEM/WB contents are discarded and a pending store is dropped. After release, the first instruction appears at the *_mem outputs after the next edge.

Test Plan:
- Reset: drive rst=1 with a pending SW in EX/MEM to addr 0x10 -> all outputs 0, mem[4] unchanged. Release rst and load from 0x10 -> previous value.
- SW 0xDEADBEEF @0x20, then LB/LBU/LH/LHU/LW @0x20..0x23 back-to-back:
  - LB @0x23 -> 0xFFFFFFDE; LBU @0x23 -> 0x000000DE.
  - LH @0x22 -> 0xFFFFDEAD; LHU @0x20 -> 0x0000BEEF.
  - LW -> 0xDEADBEEF.
  - Each result appears on wb_data two edges after EX.
- SB 0x55 @0x21 over 0xDEADBEEF, then LW @0x20 in the next cycle -> 0xDEAD55EF; first load after the store already sees the new data.
- Misaligned LW @0x22, rd=5, regwrite=1 -> mem_fault_wb=1 for one cycle, regwrite_wb_out=0, wb_data=0. Misaligned SH @0x31 -> memory unchanged, fault pulse.
- ALU op pipeline: alu_result_ex=0x1234, rd=7, regwrite=1, memtoreg=0 -> edge1: alu_result_mem=0x1234, rd_mem_out=7. Edge2: wb_data=0x1234, rd_wb_out=7, regwrite_wb_out=1.
- Address wrap with DMEM_WORDS=1024: SW 0xA5A5A5A5 @0x1000, then LW @0x0 -> 0xA5A5A5A5.
